// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/write-back controller: opcodes, FSM
// states, instruction field positions and status-flag bit indices.
package alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_AND     = 4'd2;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_MOV     = 4'd4;
    localparam logic [3:0] OP_SHL     = 4'd5;
    localparam logic [3:0] OP_SHR     = 4'd6;
    localparam logic [3:0] OP_INC     = 4'd7;
    localparam logic [3:0] OP_DEC     = 4'd8;
    localparam logic [3:0] OP_ILLEGAL = 4'd9;
    localparam logic [3:0] OP_LDI     = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Instruction field LSB positions (16-bit word)
    localparam int F_OP_LO    = 12;
    localparam int F_RD_LO    = 10;
    localparam int F_RA_LO    = 8;
    localparam int F_RB_LO    = 6;
    localparam int F_WR_RD    = 5;
    localparam int F_WR_FLAGS = 4;
    localparam int F_IMM_LO   = 0;

    localparam int FLAG_C  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_OV = 0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_DEC;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: combinational reads on two operand ports and a debug
// port, one clocked write port, every entry cleared by synchronous reset.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DEPTH*DATA_W-1:0] flat_rf;

    // One register per entry so every word can be reset in the same cycle
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (we && (wr_addr == ADDR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign flat_rf[gi*DATA_W +: DATA_W] = entry_reg;
        end
    endgenerate

    assign ra_data  = flat_rf[ra_addr*DATA_W +: DATA_W];
    assign rb_data  = flat_rf[rb_addr*DATA_W +: DATA_W];
    assign dbg_data = flat_rf[dbg_addr*DATA_W +: DATA_W];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller feeding an external combinational ALU: decodes
// one instruction per three cycles, registers operands, writes results back.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [3:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_c,
    input  logic               alu_z,
    input  logic               alu_n,
    input  logic               alu_ov,
    output logic [3:0]         flags,
    output logic               done_valid,
    output logic [DATA_W-1:0]  done_result,
    output logic               done_err,
    input  logic [1:0]         dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t            state_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    logic [3:0]        alu_op_reg;
    logic [DATA_W-1:0] res_q;
    logic [3:0]        flg_q;
    logic [3:0]        flags_reg;
    logic [1:0]        rd_q;
    logic              wr_rd_q;
    logic              wr_flags_q;
    logic              err_q;
    logic              done_valid_reg;

    logic [3:0]        f_op;
    logic [1:0]        f_rd;
    logic [1:0]        f_ra;
    logic [1:0]        f_rb;
    logic [DATA_W-1:0] f_imm;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [3:0]        flg_next;
    logic              accept;
    logic              rf_we;

    assign f_op  = instr[F_OP_LO +: 4];
    assign f_rd  = instr[F_RD_LO +: 2];
    assign f_ra  = instr[F_RA_LO +: 2];
    assign f_rb  = instr[F_RB_LO +: 2];
    assign f_imm = DATA_W'(instr[F_IMM_LO +: 8]);

    always_comb begin
        flg_next          = '0;
        flg_next[FLAG_C]  = alu_c;
        flg_next[FLAG_Z]  = alu_z;
        flg_next[FLAG_N]  = alu_n;
        flg_next[FLAG_OV] = alu_ov;
    end

    assign instr_ready = (state_reg == IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign rf_we       = (state_reg == WRITE) && wr_rd_q;

    alu_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (4),
        .ADDR_W (2)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .wr_addr  (rd_q),
        .wr_data  (res_q),
        .ra_addr  (f_ra),
        .ra_data  (ra_data),
        .rb_addr  (f_rb),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_op_reg     <= '0;
            res_q          <= '0;
            flg_q          <= '0;
            flags_reg      <= '0;
            rd_q           <= '0;
            wr_rd_q        <= 1'b0;
            wr_flags_q     <= 1'b0;
            err_q          <= 1'b0;
            done_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_valid_reg <= 1'b0;
                    if (accept) begin
                        state_reg <= ISSUE;
                        rd_q      <= f_rd;
                        if (f_op == OP_LDI) begin
                            alu_a_reg  <= f_imm;
                            alu_b_reg  <= '0;
                            alu_op_reg <= OP_MOV;
                            wr_rd_q    <= 1'b1;
                            wr_flags_q <= 1'b0;
                            err_q      <= 1'b0;
                        end else if (is_alu_op(f_op)) begin
                            alu_a_reg  <= ra_data;
                            alu_b_reg  <= rb_data;
                            alu_op_reg <= f_op;
                            wr_rd_q    <= instr[F_WR_RD];
                            wr_flags_q <= instr[F_WR_FLAGS];
                            err_q      <= 1'b0;
                        end else begin
                            alu_a_reg  <= '0;
                            alu_b_reg  <= '0;
                            alu_op_reg <= OP_ILLEGAL;
                            wr_rd_q    <= 1'b0;
                            wr_flags_q <= 1'b0;
                            err_q      <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // ALU has had a full cycle to settle on the registered operands
                    res_q          <= alu_result;
                    flg_q          <= flg_next;
                    done_valid_reg <= 1'b1;
                    state_reg      <= WRITE;
                end
                WRITE: begin
                    if (wr_flags_q) begin
                        flags_reg <= flg_q;
                    end
                    done_valid_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: begin
                    done_valid_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    // A reset arriving during WRITE cancels the completion that cycle
    assign done_valid  = done_valid_reg && !rst;
    assign done_err    = done_valid && err_q;
    assign done_result = res_q;
    assign flags       = flags_reg;
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_op      = alu_op_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural 8-bit ALU closing the
// loop; expected results are queued at issue and popped on done_valid.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_c, alu_z, alu_n, alu_ov;
    logic [3:0]  flags;
    logic        done_valid;
    logic [7:0]  done_result;
    logic        done_err;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    typedef struct packed {
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       sb_e;
    int         acc_cyc[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         cyc      = 0;
    logic [7:0] m_rf[4];
    logic [3:0] m_flags;
    logic [7:0] last_res;
    logic       last_err;
    logic [3:0] tbl_op[6] = '{OP_AND, OP_OR, OP_SHL, OP_SHR, OP_DEC, OP_MOV};

    always #10 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(8), .INSTR_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_c       (alu_c),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .alu_ov      (alu_ov),
        .flags       (flags),
        .done_valid  (done_valid),
        .done_result (done_result),
        .done_err    (done_err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural ALU: returns {result, C, Z, N, OV}; SUB carry means borrow
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, ov;
        s = '0; r = '0; c = 1'b0; ov = 1'b0;
        case (op)
            OP_ADD: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[7:0];
                c  = s[8];
                ov = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                r  = a - b;
                c  = (a < b);
                ov = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_MOV: r = a;
            OP_SHL: begin r = {a[6:0], 1'b0}; c = a[7]; end
            OP_SHR: begin r = {1'b0, a[7:1]}; c = a[0]; end
            OP_INC: begin r = b + 8'd1; c = (b == 8'hFF); ov = (b == 8'h7F); end
            OP_DEC: begin r = b - 8'd1; c = (b == 8'h00); ov = (b == 8'h80); end
            default: r = '0;
        endcase
        return {r, c, (r == 8'h00), r[7], ov};
    endfunction

    assign {alu_result, alu_c, alu_z, alu_n, alu_ov} = alu_fn(alu_a, alu_b, alu_op);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic wrd, input logic wfl);
        return {op, rd, ra, rb, wrd, wfl, 4'b0000};
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {OP_LDI, rd, 2'b00, imm};
    endfunction

    // Reference model: computes the expected completion and commits the write-back
    function automatic exp_t predict(input logic [15:0] w);
        logic [3:0]  op = w[15:12];
        logic [11:0] r;
        exp_t        e;
        if (op == OP_LDI) begin
            e.res = w[7:0];
            e.err = 1'b0;
            m_rf[w[11:10]] = w[7:0];
        end else if (op <= OP_DEC) begin
            r     = alu_fn(m_rf[w[9:8]], m_rf[w[7:6]], op);
            e.res = r[11:4];
            e.err = 1'b0;
            if (w[5]) m_rf[w[11:10]] = r[11:4];
            if (w[4]) m_flags = r[3:0];
        end else begin
            r     = alu_fn(8'h00, 8'h00, OP_ILLEGAL);
            e.res = r[11:4];
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Monitor: record accepts, score each completion
    always @(negedge clk) begin
        cyc++;
        if (instr_valid && instr_ready) acc_cyc.push_back(cyc);
        if (done_valid) begin
            done_cnt++;
            last_res = done_result;
            last_err = done_err;
            $display("done #%0d result=0x%02h err=%0b flags_before=%04b", done_cnt,
                     done_result, done_err, flags);
            check_val("sb_nonempty", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                sb_e = sb_q.pop_front();
                check_val("done_result", done_result, sb_e.res);
                check_val("done_err", done_err, sb_e.err);
            end
        end
    end

    // Called at posedge+1; finishes before the following negedge
    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check_val($sformatf("%s_rf%0d", tag, i), dbg_data, m_rf[i]);
        end
        check_val({tag, "_flags"}, flags, m_flags);
    endtask

    task automatic issue(input logic [15:0] w);
        logic [3:0] op = w[15:12];
        logic [7:0] ea, eb;
        logic [3:0] eop;
        int         waited = 0;
        if (op == OP_LDI) begin
            ea = w[7:0]; eb = 8'h00; eop = OP_MOV;
        end else if (op <= OP_DEC) begin
            ea = m_rf[w[9:8]]; eb = m_rf[w[7:6]]; eop = op;
        end else begin
            ea = 8'h00; eb = 8'h00; eop = OP_ILLEGAL;
        end
        while (!instr_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_val("ready_wait", instr_ready, 1);
        sb_q.push_back(predict(w));
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        @(negedge clk);
        check_val("issue_alu_a", alu_a, ea);
        check_val("issue_alu_b", alu_b, eb);
        check_val("issue_alu_op", alu_op, eop);
        check_val("issue_no_done", done_valid, 0);
        @(negedge clk);
        check_val("write_done", done_valid, 1);
        @(posedge clk); #1;
        $display("issued instr=0x%04h op=%0d", w, op);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          start, acc0, waited;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_flags     = 4'h0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 2'd0;

        // Reset held two cycles
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("ready_in_rst", instr_ready, 0);
        rst = 1'b0;
        #1;
        check_val("ready_after_rst", instr_ready, 1);
        check_val("rst_done_valid", done_valid, 0);
        check_val("rst_alu_op", alu_op, 0);
        check_val("rst_alu_a", alu_a, 0);
        check_val("rst_done_result", done_result, 0);
        @(posedge clk); #1;
        check_state("rst");

        // LDI r1=0x7F, r2=0x01
        issue(mk_ldi(2'd1, 8'h7F));
        check_val("ldi1_result", last_res, 8'h7F);
        issue(mk_ldi(2'd2, 8'h01));
        check_val("ldi2_result", last_res, 8'h01);
        check_val("ldi_flags", flags, 4'b0000);
        check_state("ldi");

        // ADD with signed overflow
        issue(mk(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b1, 1'b1));
        check_val("add_result", last_res, 8'h80);
        check_val("add_flags", flags, 4'b0011);
        check_state("add");

        // Compare equal: SUB without destination write
        issue(mk_ldi(2'd0, 8'h05));
        issue(mk(OP_SUB, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1));
        check_val("cmp_result", last_res, 8'h00);
        check_val("cmp_flags", flags, 4'b0100);
        check_state("cmp");

        // Illegal opcode: no state change, error reported
        issue(mk(4'd12, 2'd1, 2'd1, 2'd2, 1'b1, 1'b1));
        check_val("illegal_err", last_err, 1);
        check_state("illegal");

        // Remaining opcodes across rotating register selections
        for (int i = 0; i < 6; i++) begin
            issue(mk(tbl_op[i], 2'(i), 2'(i + 1), 2'(i + 2), 1'b1, 1'b1));
            check_state($sformatf("op%0d", tbl_op[i]));
        end

        // Back-to-back INC with instr_valid held high
        issue(mk_ldi(2'd0, 8'hFF));
        w = mk(OP_INC, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1);
        sb_q.push_back(predict(w));
        sb_q.push_back(predict(w));
        acc0        = acc_cyc.size();
        start       = done_cnt;
        instr_valid = 1'b1;
        instr       = w;
        waited      = 0;
        while (done_cnt < start + 2 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        instr_valid = 1'b0;
        check_val("b2b_done_cnt", done_cnt, start + 2);
        repeat (4) @(posedge clk);
        #1;
        check_val("b2b_accepts", acc_cyc.size() - acc0, 2);
        if (acc_cyc.size() >= acc0 + 2)
            check_val("b2b_spacing", acc_cyc[acc0 + 1] - acc_cyc[acc0], 3);
        check_val("b2b_last_result", last_res, 8'h01);
        check_state("b2b");

        // Reset asserted during WRITE of an ADD
        start       = done_cnt;
        instr_valid = 1'b1;
        instr       = mk(OP_ADD, 2'd2, 2'd1, 2'd1, 1'b1, 1'b1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_flags = 4'h0;
        #1;
        check_val("midrst_ready", instr_ready, 1);
        check_val("midrst_no_done", done_cnt, start);
        @(posedge clk); #1;
        check_val("midrst_no_done_late", done_cnt, start);
        check_state("midrst");

        check_val("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/write-back controller that sits directly upstream of the combinational 8-bit gate-level ALU. It accepts 16-bit instruction words over a valid/ready handshake, reads operands from an internal 4×8 register file, and drives the ALU's A, B and op_sel inputs from registers. It then captures the ALU result and C/Z/N/OV flags and writes them back to the register file and a status register, reporting completion with a one-cycle done pulse.

## Interface
Parameters:
- DATA_W, 8: datapath width; must equal ALU width.
- INSTR_W, 16: instruction width; field map below is fixed for 16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept; high only in IDLE.
- instr  in  16  instruction word.
- alu_a  out  8  registered operand A to ALU.
- alu_b  out  8  registered operand B to ALU.
- alu_op  out  4  registered op_sel to ALU.
- alu_result  in  8  ALU result.
- alu_c, alu_z, alu_n, alu_ov  in  1 each  ALU flags.
- flags  out  4  status register {C,Z,N,OV}.
- done_valid  out  1  one-cycle completion pulse.
- done_result  out  8  captured result, valid with done_valid.
- done_err  out  1  illegal opcode, valid with done_valid.
- dbg_addr  in  2  debug register-file read address.
- dbg_data  out  8  combinational read of rf[dbg_addr].

## Operation
- Instruction fields:
  - [15:12] op.
  - [11:10] rd.
  - [9:8] ra.
  - [7:6] rb.
  - [5] wr_rd.
  - [4] wr_flags.
  - [3:0] reserved, ignored.
  - For op=15 (LDI), [7:0] is imm and [9:4] are ignored.
- ALU opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MOV(A), 5 SHL(A), 6 SHR(A), 7 INC(B), 8 DEC(B).
  - 9–14 are illegal.
- Accept when instr_valid && instr_ready. On accept:
  - ops 0–8: alu_a<=rf[ra], alu_b<=rf[rb], alu_op<=op.
  - LDI: alu_a<=imm, alu_b<=0, alu_op<=4. Effectively wr_rd=1, wr_flags=0.
  - illegal ops: alu_op<=9, operands 0. No rf or flag write; done_err=1.
- FSM states IDLE → ISSUE → WRITE → IDLE, unconditional after accept.
  - IDLE: instr_ready=1.
  - ISSUE: ALU settles; at end of cycle res_q<=alu_result and flg_q<={alu_c,alu_z,alu_n,alu_ov}.
  - WRITE: done_valid=1, done_result=res_q. At end of cycle, if wr_rd then rf[rd]<=res_q; if wr_flags then flags<=flg_q.
- Compare is SUB with wr_rd=0, wr_flags=1.
- Flags are stored exactly as the ALU delivers them; no recomputation here.
- Register file is not written in IDLE or ISSUE. An instruction reading rd of the previous instruction sees the written value, because acceptance occurs after WRITE.
- dbg_data reflects rf contents as of the last clock edge.

## Timing
- Reset: a synchronous rst=1 at a rising edge forces the following.
  - Control: state=IDLE; done_valid=0, done_err=0.
  - Registers: all rf entries, flags, alu_a, alu_b, alu_op, res_q, flg_q = 0.
  - instr_ready=0 while rst is high, and 1 in the first cycle after release.
- Latency: accept at edge 0; ISSUE in cycle 1; WRITE/done_valid in cycle 2; rf/flags updated at edge 3. The next accept is possible at edge 3.
- Throughput: one instruction per 3 cycles.
- Handshake:
  - instr may change freely while instr_ready=0.
  - The word is sampled only on the accepting edge.
  - No backpressure on done.
- Reset mid-operation (ISSUE or WRITE) aborts with no rf/flag write and no done_valid.
- Writes to the same register from consecutive instructions simply overwrite, and 8-bit values wrap naturally.

## Structure
- Shared package alu_pkg:
  - opcode constants (OP_ADD..OP_DEC, OP_LDI=15, OP_ILLEGAL=9),
  - state enum {IDLE, ISSUE, WRITE},
  - instruction field bit positions,
  - flag bit indices (C=3, Z=2, N=1, OV=0).
- One sub-module, alu_regfile: 4×8 storage with two synchronous-use read ports (ra, rb), one debug read port and one write port. All ports are combinational read with clocked write under synchronous reset.
- The ALU itself is instantiated beside this block by the parent, not inside it.

## Test plan
- Reset/LDI:
  - Stimulus: hold rst two cycles, release; send LDI rd=1 imm=0x7F and LDI rd=2 imm=0x01.
  - Response: instr_ready=1 in the first cycle after release; done_result=0x7F then 0x01; flags remain 0000; dbg rf[1]=0x7F.
- ADD overflow:
  - Stimulus: ADD rd=3 ra=1 rb=2 wr_rd=1 wr_flags=1.
  - Response: alu_a=0x7F, alu_b=0x01, alu_op=0 in cycle 1; done_result=0x80 in cycle 2; rf[3]=0x80; flags N=1, OV=1, Z=0.
- Compare equal:
  - Stimulus: LDI r0=0x05, then SUB ra=0 rb=0 wr_rd=0 wr_flags=1.
  - Response: done_result=0x00, flags Z=1, rf unchanged.
- Illegal opcode:
  - Stimulus: op=12.
  - Response: done_valid with done_err=1 two cycles after accept; rf and flags unchanged; alu_op=9 during ISSUE.
- Handshake spacing:
  - Stimulus: instr_valid held high with back-to-back INC rd=0 rb=0, starting from r0=0xFF.
  - Response: accepts exactly every 3 cycles; results 0x00 then 0x01.
- Mid-operation reset:
  - Stimulus: assert rst in WRITE of an ADD.
  - Response: no done_valid; rf[rd] and flags read 0; state IDLE after release.
